// File: rtl/decode_sequencer.sv
// decode_sequencer: 2-entry in-order instruction buffer with load-use scoreboard between fetch and decode/execute.
// Define DECODE_PERF_EN to add saturating stall_cnt/issue_cnt outputs.
module decode_sequencer (
  input  logic        clk,
  input  logic        nRst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        flush,
  output logic [31:0] dec_inst,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic [2:0]  dec_type,
  input  logic [16:0] dec_ctrl,
  output logic        dec_valid,
  input  logic        ex_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] busy_regs,
  output logic        stall
`ifdef DECODE_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] issue_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, HOLD1, HOLD2} state_t;
  state_t state, state_nxt;
  logic [31:0] head, tail;
  logic push, pop, hazard, rs1_hit, rs2_hit, no_srcs, set_busy, clr_busy;
  logic [31:0] set_mask, clr_mask;
  logic unused;
  assign unused = ^dec_ctrl[9:0];
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) state <= EMPTY;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = EMPTY;
    else if (state == EMPTY) state_nxt = push ? HOLD1 : EMPTY;
    else if (state == HOLD1) state_nxt = (push && !pop) ? HOLD2 : (pop && !push) ? EMPTY : HOLD1;
    else if (state == HOLD2) state_nxt = pop ? HOLD1 : HOLD2;
  end
  always_comb begin
    if_ready = state != HOLD2;
    dec_inst = state == EMPTY ? 32'h0 : head;
    no_srcs = dec_type == 3'd4 || dec_type == 3'd5;
    rs1_hit = dec_rs1 != 5'd0 && busy_regs[dec_rs1];
    rs2_hit = dec_rs2 != 5'd0 && busy_regs[dec_rs2];
    hazard = state != EMPTY && !no_srcs && (rs1_hit || rs2_hit);
    stall = hazard;
    dec_valid = state != EMPTY && !hazard;
  end
  // Flush kills both the incoming push and the outgoing issue, including its scoreboard set.
  assign push = if_valid && if_ready && !flush;
  assign pop = dec_valid && ex_ready && !flush;
  assign set_busy = pop && dec_ctrl[16:10] == 7'b0000011 && dec_rd != 5'd0;
  assign clr_busy = wb_valid && wb_rd != 5'd0;
  assign set_mask = set_busy ? 32'd1 << dec_rd : 32'd0;
  assign clr_mask = clr_busy ? 32'd1 << wb_rd : 32'd0;
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      head <= 32'h0;
      tail <= 32'h0;
      busy_regs <= 32'h0;
    end else begin
      if (pop && state == HOLD2) head <= tail;
      else if (push && (state == EMPTY || pop)) head <= if_inst;
      if (push && state == HOLD1 && !pop) tail <= if_inst;
      busy_regs <= (busy_regs & ~clr_mask) | set_mask;
    end
`ifdef DECODE_PERF_EN
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      stall_cnt <= 16'h0;
      issue_cnt <= 16'h0;
    end else begin
      stall_cnt <= stall_cnt + {15'd0, stall && stall_cnt != 16'hFFFF};
      issue_cnt <= issue_cnt + {15'd0, pop && issue_cnt != 16'hFFFF};
    end
`endif
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed tests for decode_sequencer with a behavioural RV32 field decoder.
module tb_decode_sequencer;
  logic clk = 0, nRst = 0, if_valid = 0, if_ready, flush = 0, dec_valid, ex_ready = 0, wb_valid = 0, stall;
  logic [31:0] if_inst = 0, dec_inst, busy_regs;
  logic [4:0] dec_rs1, dec_rs2, dec_rd, wb_rd = 0;
  logic [2:0] dec_type;
  logic [16:0] dec_ctrl;
`ifdef DECODE_PERF_EN
  logic [15:0] stall_cnt, issue_cnt;
`endif
  int vecs = 0, errs = 0;
  localparam logic [31:0] W1 = 32'h00208033, W2 = 32'h00310133, LW5 = 32'h0002A283, ADD = 32'h00128333;
  localparam logic [31:0] LW0 = 32'h00002003, LW7 = 32'h00002383, NOP = 32'h00000013, ADDI1 = 32'h00100093, ADDI2 = 32'h00200113;
  decode_sequencer dut (
    .clk(clk), .nRst(nRst), .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready), .flush(flush),
    .dec_inst(dec_inst), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_type(dec_type),
    .dec_ctrl(dec_ctrl), .dec_valid(dec_valid), .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy_regs(busy_regs), .stall(stall)
`ifdef DECODE_PERF_EN
    , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
  );
  always #5 clk = ~clk;
  always_comb begin
    dec_rs1 = dec_inst[19:15];
    dec_rs2 = dec_inst[24:20];
    dec_rd = dec_inst[11:7];
    dec_ctrl = {dec_inst[6:0], 10'd0};
    case (dec_inst[6:0])
      7'b0110011: dec_type = 3'd0;
      7'b0100011: dec_type = 3'd2;
      7'b1100011: dec_type = 3'd3;
      7'b1101111: dec_type = 3'd4;
      7'b0110111, 7'b0010111: dec_type = 3'd5;
      default: dec_type = 3'd1;
    endcase
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (2) tick;
    vecs++; if (if_ready !== 1'b1) begin errs++; $display("FAIL rst_if_ready got=%b exp=1", if_ready); end
    vecs++; if (dec_inst !== 32'h0) begin errs++; $display("FAIL rst_dec_inst got=%h exp=0", dec_inst); end
    vecs++; if (dec_valid !== 1'b0) begin errs++; $display("FAIL rst_dec_valid got=%b exp=0", dec_valid); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall got=%b exp=0", stall); end
    vecs++; if (busy_regs !== 32'h0) begin errs++; $display("FAIL rst_busy got=%h exp=0", busy_regs); end
    nRst = 1;
    tick;
  endtask
  task automatic test_back_to_back;
    ex_ready = 1; if_valid = 1; if_inst = W1;
    #1;
    vecs++; if (if_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready got=%b exp=1", if_ready); end
    tick;
    if_inst = W2;
    #1;
    vecs++; if (dec_inst !== W1) begin errs++; $display("FAIL b2b_first got=%h exp=%h", dec_inst, W1); end
    vecs++; if (dec_valid !== 1'b1 || stall !== 1'b0) begin errs++; $display("FAIL b2b_first_vs got=%b%b exp=10", dec_valid, stall); end
    tick;
    if_valid = 0;
    #1;
    vecs++; if (dec_inst !== W2) begin errs++; $display("FAIL b2b_second got=%h exp=%h", dec_inst, W2); end
    vecs++; if (dec_valid !== 1'b1 || stall !== 1'b0) begin errs++; $display("FAIL b2b_second_vs got=%b%b exp=10", dec_valid, stall); end
    tick;
    vecs++; if (dec_valid !== 1'b0 || dec_inst !== 32'h0) begin errs++; $display("FAIL b2b_drain got=%b/%h exp=0/0", dec_valid, dec_inst); end
  endtask
  task automatic test_load_use;
    ex_ready = 1; if_valid = 1; if_inst = LW5;
    tick;
    if_inst = ADD;
    #1;
    vecs++; if (dec_inst !== LW5 || dec_valid !== 1'b1) begin errs++; $display("FAIL lu_lw got=%h/%b exp=%h/1", dec_inst, dec_valid, LW5); end
    tick;
    if_valid = 0;
    #1;
    vecs++; if (busy_regs !== 32'h20) begin errs++; $display("FAIL lu_busy_set got=%h exp=00000020", busy_regs); end
    vecs++; if (stall !== 1'b1 || dec_valid !== 1'b0) begin errs++; $display("FAIL lu_stall got=%b%b exp=10", stall, dec_valid); end
    vecs++; if (dec_inst !== ADD) begin errs++; $display("FAIL lu_head got=%h exp=%h", dec_inst, ADD); end
    tick;
    wb_valid = 1; wb_rd = 5;
    #1;
    vecs++; if (stall !== 1'b1 || dec_valid !== 1'b0) begin errs++; $display("FAIL lu_stall_wb got=%b%b exp=10", stall, dec_valid); end
    tick;
    wb_valid = 0; wb_rd = 0;
    #1;
    vecs++; if (busy_regs !== 32'h0) begin errs++; $display("FAIL lu_busy_clr got=%h exp=0", busy_regs); end
    vecs++; if (stall !== 1'b0 || dec_valid !== 1'b1) begin errs++; $display("FAIL lu_release got=%b%b exp=01", stall, dec_valid); end
    tick;
    vecs++; if (dec_valid !== 1'b0) begin errs++; $display("FAIL lu_drain got=%b exp=0", dec_valid); end
`ifdef DECODE_PERF_EN
    vecs++; if (stall_cnt !== 16'd2) begin errs++; $display("FAIL lu_stall_cnt got=%0d exp=2", stall_cnt); end
    vecs++; if (issue_cnt !== 16'd4) begin errs++; $display("FAIL lu_issue_cnt got=%0d exp=4", issue_cnt); end
`endif
  endtask
  task automatic test_same_cycle;
    ex_ready = 1; if_valid = 1; if_inst = LW0;
    tick;
    if_valid = 0;
    #1;
    vecs++; if (dec_valid !== 1'b1) begin errs++; $display("FAIL sc_lw0_valid got=%b exp=1", dec_valid); end
    tick;
    vecs++; if (busy_regs !== 32'h0) begin errs++; $display("FAIL sc_lw0_busy got=%h exp=0", busy_regs); end
    if_valid = 1; if_inst = LW7;
    tick;
    if_valid = 0; wb_valid = 1; wb_rd = 7;
    #1;
    vecs++; if (dec_valid !== 1'b1) begin errs++; $display("FAIL sc_lw7_valid got=%b exp=1", dec_valid); end
    tick;
    wb_valid = 0; wb_rd = 0;
    #1;
    vecs++; if (busy_regs !== 32'h80) begin errs++; $display("FAIL sc_set_wins got=%h exp=00000080", busy_regs); end
  endtask
  task automatic test_flush;
    ex_ready = 0; if_valid = 1; if_inst = NOP;
    tick;
    if_inst = ADDI1;
    tick;
    if_inst = ADDI2;
    #1;
    vecs++; if (if_ready !== 1'b0) begin errs++; $display("FAIL fl_hold2 got=%b exp=0", if_ready); end
    flush = 1;
    tick;
    flush = 0; if_valid = 0;
    #1;
    vecs++; if (dec_valid !== 1'b0 || dec_inst !== 32'h0 || if_ready !== 1'b1) begin errs++; $display("FAIL fl_empty got=%b/%h/%b exp=0/0/1", dec_valid, dec_inst, if_ready); end
    vecs++; if (busy_regs !== 32'h80) begin errs++; $display("FAIL fl_busy got=%h exp=00000080", busy_regs); end
    if_valid = 1; if_inst = NOP;
    tick;
    ex_ready = 1; flush = 1; if_inst = ADDI1;
    tick;
    flush = 0; if_valid = 0;
    #1;
    vecs++; if (dec_valid !== 1'b0 || dec_inst !== 32'h0) begin errs++; $display("FAIL fl_push_drop got=%b/%h exp=0/0", dec_valid, dec_inst); end
`ifdef DECODE_PERF_EN
    vecs++; if (issue_cnt !== 16'd6) begin errs++; $display("FAIL fl_issue_cnt got=%0d exp=6", issue_cnt); end
`endif
    wb_valid = 1; wb_rd = 7;
    tick;
    wb_valid = 0; wb_rd = 0;
    #1;
    vecs++; if (busy_regs !== 32'h0) begin errs++; $display("FAIL fl_wb_clr got=%h exp=0", busy_regs); end
    ex_ready = 0;
  endtask
  task automatic test_full;
    ex_ready = 0; if_valid = 1; if_inst = NOP;
    tick;
    if_inst = ADDI1;
    #1;
    vecs++; if (if_ready !== 1'b1 || dec_inst !== NOP) begin errs++; $display("FAIL full_hold1 got=%b/%h exp=1/%h", if_ready, dec_inst, NOP); end
    tick;
    if_inst = ADDI2;
    #1;
    vecs++; if (if_ready !== 1'b0 || dec_inst !== NOP) begin errs++; $display("FAIL full_hold2 got=%b/%h exp=0/%h", if_ready, dec_inst, NOP); end
    tick;
    vecs++; if (if_ready !== 1'b0 || dec_inst !== NOP) begin errs++; $display("FAIL full_held got=%b/%h exp=0/%h", if_ready, dec_inst, NOP); end
    ex_ready = 1;
    tick;
    vecs++; if (if_ready !== 1'b1 || dec_inst !== ADDI1) begin errs++; $display("FAIL full_pop1 got=%b/%h exp=1/%h", if_ready, dec_inst, ADDI1); end
    tick;
    if_valid = 0;
    #1;
    vecs++; if (dec_inst !== ADDI2 || dec_valid !== 1'b1) begin errs++; $display("FAIL full_third got=%h/%b exp=%h/1", dec_inst, dec_valid, ADDI2); end
    tick;
    vecs++; if (dec_valid !== 1'b0) begin errs++; $display("FAIL full_drain got=%b exp=0", dec_valid); end
  endtask
  task automatic test_reset_mid_stall;
    ex_ready = 1; if_valid = 1; if_inst = LW5;
    tick;
    if_inst = ADD;
    tick;
    if_valid = 0;
    #1;
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL rms_stall got=%b exp=1", stall); end
`ifdef DECODE_PERF_EN
    vecs++; if (stall_cnt !== 16'd2) begin errs++; $display("FAIL rms_stall_cnt_pre got=%0d exp=2", stall_cnt); end
`endif
    tick;
    #2 nRst = 0;
    #1;
    vecs++; if (busy_regs !== 32'h0 || stall !== 1'b0) begin errs++; $display("FAIL rms_busy got=%h/%b exp=0/0", busy_regs, stall); end
    vecs++; if (dec_valid !== 1'b0 || if_ready !== 1'b1 || dec_inst !== 32'h0) begin errs++; $display("FAIL rms_empty got=%b/%b/%h exp=0/1/0", dec_valid, if_ready, dec_inst); end
`ifdef DECODE_PERF_EN
    vecs++; if (stall_cnt !== 16'd0 || issue_cnt !== 16'd0) begin errs++; $display("FAIL rms_cnt got=%0d/%0d exp=0/0", stall_cnt, issue_cnt); end
`endif
    tick;
    if_valid = 1; if_inst = ADDI1;
    nRst = 1;
    tick;
    if_valid = 0;
    #1;
    vecs++; if (dec_inst !== ADDI1 || dec_valid !== 1'b1) begin errs++; $display("FAIL rms_first_accept got=%h/%b exp=%h/1", dec_inst, dec_valid, ADDI1); end
    tick;
    ex_ready = 0;
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_load_use;
    test_same_cycle;
    test_flush;
    test_full;
    test_reset_mid_stall;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: nRst  input  1  asynchronous reset, active-low.
REQ-003 SHALL have port: if_valid  input  1  fetch presents an instruction.
REQ-004 SHALL have port: if_inst  input  32  instruction word from fetch.
REQ-005 SHALL have port: if_ready  output  1  sequencer accepts if_inst this cycle.
REQ-006 SHALL have port: flush  input  1  discard all buffered instructions.
REQ-007 SHALL have port: dec_inst  output  32  head instruction driven to decoder inst.
REQ-008 SHALL have ports: dec_rs1, dec_rs2, dec_rd  input  5 each  decoder register fields for dec_inst.
REQ-009 SHALL have port: dec_type  input  3  decoder type_out (R=0, I=1, S=2, SB=3, UJ=4, U=5).
REQ-010 SHALL have port: dec_ctrl  input  17  decoder control_out; opcode = dec_ctrl[16:10].
REQ-011 SHALL have port: dec_valid  output  1  head instruction is issuable.
REQ-012 SHALL have port: ex_ready  input  1  execute stage accepts issued instruction.
REQ-013 SHALL have ports: wb_valid  input  1, wb_rd  input  5  load writeback completes to wb_rd.
REQ-014 SHALL have port: busy_regs  output  32  scoreboard, bit n = load pending to xn.
REQ-015 SHALL have port: stall  output  1  head held by RAW hazard.

Function
REQ-016 SHALL hold instructions in 2-entry in-order FIFO; occupancy FSM states EMPTY, HOLD1, HOLD2.
REQ-017 SHALL drive if_ready = 1 in EMPTY and HOLD1, 0 in HOLD2; push when if_valid && if_ready.
REQ-018 SHALL drive dec_inst = head entry, 32'h0 in EMPTY.
REQ-019 SHALL compute hazard = head present && ((rs1 check) || (rs2 check)); check = field != 0 && busy_regs[field]; both checks ignored for dec_type U or UJ.
REQ-020 SHALL drive stall = hazard, dec_valid = head present && !hazard, combinationally.
REQ-021 SHALL pop head when dec_valid && ex_ready (issue); simultaneous push and pop keeps occupancy, HOLD1->HOLD1, HOLD2->HOLD2 impossible (if_ready=0).
REQ-022 SHALL on issue with opcode 7'b0000011 and dec_rd != 0 set busy_regs[dec_rd] next edge.
REQ-023 SHALL on wb_valid && wb_rd != 0 clear busy_regs[wb_rd] next edge; x0 never set.
REQ-024 SHALL give set priority over clear when both target same register in one cycle.
REQ-025 SHALL use registered busy_regs for hazard; issue after writeback earliest cycle after wb_valid.
REQ-026 SHALL on flush go to EMPTY next edge, dropping any same-cycle push and suppressing issue; busy_regs unaffected.
REQ-027 SHALL present instructions to execute in exact fetch order, none dropped or duplicated absent flush.

Reset
REQ-028 SHALL on nRst low immediately: FSM EMPTY, FIFO contents 0, busy_regs 0; outputs if_ready 1, dec_inst 0, dec_valid 0, stall 0.
REQ-029 SHALL discard in-progress pushes/issues when reset asserts mid-operation; first accept on first edge after release.

Configuration
REQ-030 SHALL, with DECODE_PERF_EN defined, add outputs stall_cnt 16 and issue_cnt 16: saturating counters (hold 16'hFFFF) of stall cycles and issues, reset 0, unaffected by flush.
REQ-031 SHALL, without DECODE_PERF_EN, omit those ports and counters; all other behaviour identical.

Verification
REQ-032 SHALL cover back-to-back: ex_ready=1, fetch 0x00208033 then 0x00310133 -> each issued one cycle after accept, order kept, stall 0.
REQ-033 SHALL cover load-use: issue lw x5 (0x0002A283), then add x6,x5,x1 (0x00128333) -> stall=1, dec_valid=0 until wb_valid wb_rd=5; issue one cycle later; busy_regs[5] 1 then 0.
REQ-034 SHALL cover full: ex_ready=0, if_valid=1 three words -> two accepted, if_ready=0 in HOLD2, third held at fetch, accepted after one issue.
REQ-035 SHALL cover flush in HOLD2 with if_valid=1 -> EMPTY next cycle, dec_valid=0, pushed word dropped, busy_regs unchanged.
REQ-036 SHALL cover same-cycle set/clear: issue lw x7 while wb_valid wb_rd=7 -> busy_regs[7]=1; lw x0 -> busy_regs stays 0.
REQ-037 SHALL cover reset mid-stall with DECODE_PERF_EN: nRst low -> busy_regs 0, stall_cnt 0, EMPTY immediately.
